// File: rtl/spi_shift_engine_if.sv
// Signal bundle between the core-side bus, the SPI clock stage and spi_shift_engine.
// The slave modport is the engine's view; master is the driving side.
interface spi_shift_engine_if #(
    parameter int unsigned DATAWIDTH = 8
);
    logic                 i_tx_valid;
    logic [DATAWIDTH-1:0] i_tx_byte;
    logic                 o_tx_ready;
    logic                 o_clk_start;
    logic                 i_leading_edge;
    logic                 i_trailing_edge;
    logic                 o_spi_mosi;
    logic                 i_spi_miso;
    logic                 o_spi_cs_n;
    logic                 o_rx_valid;
    logic [DATAWIDTH-1:0] o_rx_byte;
    logic                 o_busy;

    modport slave (
        input  i_tx_valid, i_tx_byte, i_leading_edge, i_trailing_edge, i_spi_miso,
        output o_tx_ready, o_clk_start, o_spi_mosi, o_spi_cs_n, o_rx_valid, o_rx_byte, o_busy
    );

    modport master (
        output i_tx_valid, i_tx_byte, i_leading_edge, i_trailing_edge, i_spi_miso,
        input  o_tx_ready, o_clk_start, o_spi_mosi, o_spi_cs_n, o_rx_valid, o_rx_byte, o_busy
    );
endinterface

// File: rtl/spi_shift_engine.sv
// SPI mode-0 master data path: takes a word over valid/ready and shifts it on clock-stage strobes.
// Define SPI_LSB_FIRST_EN to transmit bit 0 first; default is MSB first.
module spi_shift_engine #(
    parameter int unsigned DATAWIDTH = 8
) (
    input logic               i_clk,
    input logic               i_reset,
    spi_shift_engine_if.slave bus
);
    localparam int unsigned CntW = $clog2(DATAWIDTH + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(DATAWIDTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [DATAWIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [DATAWIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [DATAWIDTH-1:0] rx_byte_q, rx_byte_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 clk_start_q, clk_start_d;
    logic                 mosi_q, mosi_d;
    logic                 cs_n_q, cs_n_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 busy_q, busy_d;

    logic                 accept;
    logic                 first_bit;
    logic                 next_bit;
    logic [DATAWIDTH-1:0] tx_next;
    logic [DATAWIDTH-1:0] rx_shifted;

`ifdef SPI_LSB_FIRST_EN
    assign first_bit  = bus.i_tx_byte[0];
    assign tx_next    = tx_sr_q >> 1;
    assign next_bit   = tx_next[0];
    assign rx_shifted = {bus.i_spi_miso, rx_sr_q[DATAWIDTH-1:1]};
`else
    assign first_bit  = bus.i_tx_byte[DATAWIDTH-1];
    assign tx_next    = tx_sr_q << 1;
    assign next_bit   = tx_next[DATAWIDTH-1];
    assign rx_shifted = {rx_sr_q[DATAWIDTH-2:0], bus.i_spi_miso};
`endif

    assign accept = (state_q == IDLE) && tx_ready_q && bus.i_tx_valid;

    always_comb begin
        state_d     = state_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        rx_byte_d   = rx_byte_q;
        cnt_d       = cnt_q;
        mosi_d      = mosi_q;
        cs_n_d      = cs_n_q;
        busy_d      = busy_q;
        tx_ready_d  = 1'b0;
        clk_start_d = 1'b0;
        rx_valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                tx_ready_d = 1'b1;
                cs_n_d     = 1'b1;
                busy_d     = 1'b0;
                if (accept) begin
                    state_d     = SHIFT;
                    tx_sr_d     = bus.i_tx_byte;
                    rx_sr_d     = '0;
                    cnt_d       = CntFull;
                    mosi_d      = first_bit;
                    clk_start_d = 1'b1;
                    cs_n_d      = 1'b0;
                    busy_d      = 1'b1;
                    tx_ready_d  = 1'b0;
                end
            end
            SHIFT: begin
                // A leading strobe wins; a coincident trailing strobe is dropped.
                if (bus.i_leading_edge) begin
                    if (cnt_q != '0) begin
                        rx_sr_d = rx_shifted;
                        cnt_d   = cnt_q - CntW'(1);
                    end
                end else if (bus.i_trailing_edge) begin
                    if (cnt_q != '0) begin
                        tx_sr_d = tx_next;
                        mosi_d  = next_bit;
                    end else begin
                        state_d    = DONE;
                        rx_valid_d = 1'b1;
                        rx_byte_d  = rx_sr_q;
                        cs_n_d     = 1'b1;
                        busy_d     = 1'b0;
                    end
                end
            end
            DONE: begin
                state_d    = IDLE;
                tx_ready_d = 1'b1;
                cs_n_d     = 1'b1;
                busy_d     = 1'b0;
            end
            default: begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            rx_byte_q   <= '0;
            cnt_q       <= '0;
            tx_ready_q  <= 1'b0;
            clk_start_q <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            rx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            rx_byte_q   <= rx_byte_d;
            cnt_q       <= cnt_d;
            tx_ready_q  <= tx_ready_d;
            clk_start_q <= clk_start_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
            rx_valid_q  <= rx_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.o_tx_ready  = tx_ready_q;
    assign bus.o_clk_start = clk_start_q;
    assign bus.o_spi_mosi  = mosi_q;
    assign bus.o_spi_cs_n  = cs_n_q;
    assign bus.o_rx_valid  = rx_valid_q;
    assign bus.o_rx_byte   = rx_byte_q;
    assign bus.o_busy      = busy_q;
endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: drives ideal SCLK edge strobes and checks against a bit-order model.
// Honours SPI_LSB_FIRST_EN the same way the design does.
module tb_spi_shift_engine;
    localparam int W = 8;
`ifdef SPI_LSB_FIRST_EN
    localparam bit LsbFirst = 1'b1;
`else
    localparam bit LsbFirst = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    spi_shift_engine_if #(.DATAWIDTH(W)) bus ();
    spi_shift_engine #(.DATAWIDTH(W)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int edge_cnt = 0;
    int n_start = 0;
    int n_rxv = 0;
    int n_csl = 0;
    logic [W-1:0] rx_log[$];
    logic [W-1:0] exp_last_rx = '0;

    always @(negedge clk) begin
        if (bus.o_clk_start === 1'b1) n_start++;
        if (bus.o_rx_valid === 1'b1) begin
            n_rxv++;
            rx_log.push_back(bus.o_rx_byte);
        end
        if (bus.o_spi_cs_n === 1'b0) n_csl++;
    end

    // Bit i of the wire sequence (time order) for word w.
    function automatic logic model_tx_bit(input logic [W-1:0] w, input int i);
        return LsbFirst ? w[i] : w[W-1-i];
    endfunction

    function automatic logic [W-1:0] model_tx_seq(input logic [W-1:0] w);
        logic [W-1:0] s;
        for (int i = 0; i < W; i++) s[i] = model_tx_bit(w, i);
        return s;
    endfunction

    // Received word from MISO bits listed in time order.
    function automatic logic [W-1:0] model_rx(input logic [W-1:0] miso_seq);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[LsbFirst ? i : W-1-i] = miso_seq[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    task automatic accept(input logic [W-1:0] w, output bit ok);
        ok = 1'b0;
        bus.i_tx_valid = 1'b1;
        bus.i_tx_byte  = w;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (bus.o_tx_ready === 1'b1) ok = 1'b1;
            tick();
        end
        bus.i_tx_valid = 1'b0;
    endtask

    // kind: 0 loopback, 1 MISO high, 2 MISO low, other random.
    task automatic bit_cycle(input int half, input int kind, input bit both, input bit last,
                             output logic mosi_seen, output logic miso_sent,
                             output logic mosi_after);
        mosi_seen = bus.o_spi_mosi;
        case (kind)
            0:       miso_sent = bus.o_spi_mosi;
            1:       miso_sent = 1'b1;
            2:       miso_sent = 1'b0;
            default: miso_sent = 1'($urandom_range(0, 1));
        endcase
        bus.i_spi_miso      = miso_sent;
        bus.i_leading_edge  = 1'b1;
        bus.i_trailing_edge = both;
        tick();
        mosi_after          = bus.o_spi_mosi;
        bus.i_leading_edge  = 1'b0;
        bus.i_trailing_edge = 1'b0;
        repeat (half - 1) tick();
        bus.i_trailing_edge = 1'b1;
        tick();
        bus.i_trailing_edge = 1'b0;
        if (!last) repeat (half - 1) tick();
    endtask

    task automatic shift_word(input int half, input int kind, input int both_at,
                              output logic [W-1:0] mosi_seq, output logic [W-1:0] miso_seq,
                              output logic both_mosi);
        logic ms, mi, ma;
        mosi_seq  = '0;
        miso_seq  = '0;
        both_mosi = 1'b0;
        for (int i = 0; i < W; i++) begin
            bit_cycle(half, kind, (i == both_at), (i == W - 1), ms, mi, ma);
            mosi_seq[i] = ms;
            miso_seq[i] = mi;
            if (i == both_at) both_mosi = ma;
        end
    endtask

    task automatic xfer(input logic [W-1:0] w, input int half, input int kind, input int both_at,
                        output bit ok, output logic [W-1:0] mosi_seq,
                        output logic [W-1:0] miso_seq, output logic both_mosi,
                        output int cs_cycles);
        int e0;
        mosi_seq  = '0;
        miso_seq  = '0;
        both_mosi = 1'b0;
        cs_cycles = 0;
        accept(w, ok);
        if (!ok) return;
        e0 = edge_cnt;
        shift_word(half, kind, both_at, mosi_seq, miso_seq, both_mosi);
        cs_cycles = edge_cnt - e0;
    endtask

    task automatic test_reset();
        logic [13:0] got;
        rst = 1'b1;
        repeat (3) tick();
        got = {bus.o_tx_ready, bus.o_clk_start, bus.o_spi_mosi, bus.o_spi_cs_n,
               bus.o_rx_valid, bus.o_busy, bus.o_rx_byte};
        n_tests++;
        if (got !== 14'b000100_00000000) begin
            n_fail++;
            $display("FAIL reset_values: got %b want %b", got, 14'b000100_00000000);
        end
        rst = 1'b0;
        n_tests++;
        if (bus.o_tx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_early: got %b want 0", bus.o_tx_ready);
        end
        tick();
        n_tests++;
        if (bus.o_tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_first: got %b want 1", bus.o_tx_ready);
        end
    endtask

    task automatic test_loopback();
        logic [W-1:0] ms, mi, w;
        logic bm;
        bit ok;
        int csc, s0, r0, c0, half;
        s0 = n_start; r0 = n_rxv; c0 = n_csl;
        xfer(8'hA5, 4, 0, -1, ok, ms, mi, bm, csc);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL lb_accept: ready never seen, want accept"); end
        n_tests++;
        if (ms !== model_tx_seq(8'hA5)) begin
            n_fail++;
            $display("FAIL lb_mosi_seq: got %b want %b", ms, model_tx_seq(8'hA5));
        end
        n_tests++;
        if ({bus.o_rx_valid, bus.o_spi_cs_n, bus.o_tx_ready} !== 3'b110) begin
            n_fail++;
            $display("FAIL lb_done_flags: got %b want 110",
                     {bus.o_rx_valid, bus.o_spi_cs_n, bus.o_tx_ready});
        end
        n_tests++;
        if (bus.o_rx_byte !== 8'hA5) begin
            n_fail++;
            $display("FAIL lb_rx_byte: got %h want a5", bus.o_rx_byte);
        end
        tick();
        n_tests++;
        if ({bus.o_tx_ready, bus.o_rx_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL lb_ready_return: got %b want 10", {bus.o_tx_ready, bus.o_rx_valid});
        end
        tick();
        n_tests++;
        if ({n_start - s0, n_rxv - r0, n_csl - c0} !== {32'd1, 32'd1, csc}) begin
            n_fail++;
            $display("FAIL lb_pulse_counts: got start=%0d rxv=%0d csl=%0d want 1 1 %0d",
                     n_start - s0, n_rxv - r0, n_csl - c0, csc);
        end
        for (int k = 0; k < 4; k++) begin
            w    = W'($urandom);
            half = $urandom_range(2, 5);
            xfer(w, half, 3, -1, ok, ms, mi, bm, csc);
            n_tests++;
            if (!ok || ms !== model_tx_seq(w) || bus.o_rx_byte !== model_rx(mi)) begin
                n_fail++;
                $display("FAIL rand_xfer: w=%h ok=%0d mosi %b want %b rx %h want %h",
                         w, ok, ms, model_tx_seq(w), bus.o_rx_byte, model_rx(mi));
            end
            exp_last_rx = model_rx(mi);
        end
        repeat (2) tick();
    endtask

    task automatic test_fixed_miso();
        logic [W-1:0] ms, mi;
        logic bm;
        bit ok;
        int csc;
        xfer(8'h3C, 3, 1, -1, ok, ms, mi, bm, csc);
        n_tests++;
        if (ms !== model_tx_seq(8'h3C)) begin
            n_fail++;
            $display("FAIL miso1_mosi_seq: got %b want %b", ms, model_tx_seq(8'h3C));
        end
        n_tests++;
        if (bus.o_rx_byte !== 8'hFF) begin
            n_fail++;
            $display("FAIL miso1_rx: got %h want ff", bus.o_rx_byte);
        end
        repeat (2) tick();
        xfer(8'hFF, 2, 2, -1, ok, ms, mi, bm, csc);
        n_tests++;
        if (bus.o_rx_byte !== 8'h00 || bus.o_rx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL miso0_rx: got %h valid %b want 00 valid 1",
                     bus.o_rx_byte, bus.o_rx_valid);
        end
        exp_last_rx = 8'h00;
        repeat (2) tick();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ms, mi;
        logic bm;
        bit ok;
        int s0, r0, q0;
        s0 = n_start; r0 = n_rxv; q0 = rx_log.size();
        ok = 1'b0;
        bus.i_tx_valid = 1'b1;
        bus.i_tx_byte  = 8'h11;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (bus.o_tx_ready === 1'b1) ok = 1'b1;
            tick();
        end
        bus.i_tx_byte = 8'h22;
        shift_word(3, 0, -1, ms, mi, bm);
        n_tests++;
        if (!ok || bus.o_rx_valid !== 1'b1 || bus.o_rx_byte !== 8'h11) begin
            n_fail++;
            $display("FAIL b2b_first: ok=%0d valid %b rx %h want 1 11",
                     ok, bus.o_rx_valid, bus.o_rx_byte);
        end
        tick();
        n_tests++;
        if ({bus.o_spi_cs_n, bus.o_clk_start} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_gap: got cs_n,start=%b want 10", {bus.o_spi_cs_n, bus.o_clk_start});
        end
        tick();
        n_tests++;
        if ({bus.o_spi_cs_n, bus.o_clk_start} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_accept2: got cs_n,start=%b want 01",
                     {bus.o_spi_cs_n, bus.o_clk_start});
        end
        shift_word(3, 0, -1, ms, mi, bm);
        bus.i_tx_valid = 1'b0;
        repeat (6) tick();
        n_tests++;
        if (n_start - s0 != 2 || n_rxv - r0 != 2 || rx_log.size() - q0 != 2) begin
            n_fail++;
            $display("FAIL b2b_counts: got start=%0d rxv=%0d want 2 2", n_start - s0, n_rxv - r0);
        end else begin
            n_tests++;
            if ({rx_log[q0], rx_log[q0+1]} !== 16'h1122) begin
                n_fail++;
                $display("FAIL b2b_words: got %h %h want 11 22", rx_log[q0], rx_log[q0+1]);
            end
        end
        exp_last_rx = 8'h22;
    endtask

    task automatic test_reset_abort();
        logic [W-1:0] ms, mi;
        logic a, b, c, bm;
        bit ok;
        int csc, r0;
        r0 = n_rxv;
        accept(8'hC3, ok);
        bit_cycle(3, 0, 1'b0, 1'b0, a, b, c);
        bit_cycle(3, 0, 1'b0, 1'b0, a, b, c);
        bus.i_spi_miso     = bus.o_spi_mosi;
        bus.i_leading_edge = 1'b1;
        tick();
        bus.i_leading_edge = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if ({bus.o_spi_cs_n, bus.o_busy, bus.o_rx_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL abort_state: got cs_n,busy,rxv=%b want 100",
                     {bus.o_spi_cs_n, bus.o_busy, bus.o_rx_valid});
        end
        repeat (20) tick();
        n_tests++;
        if (n_rxv != r0) begin
            n_fail++;
            $display("FAIL abort_no_rxv: got %0d pulses want 0", n_rxv - r0);
        end
        xfer(8'h5A, 3, 0, -1, ok, ms, mi, bm, csc);
        n_tests++;
        if (!ok || bus.o_rx_byte !== 8'h5A || bus.o_rx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_recover: ok=%0d rx %h valid %b want 5a 1",
                     ok, bus.o_rx_byte, bus.o_rx_valid);
        end
        exp_last_rx = 8'h5A;
        repeat (2) tick();
    endtask

    task automatic test_edges();
        logic [W-1:0] ms, mi, w;
        logic [13:0] got, exp;
        logic m0, bm;
        bit ok;
        int csc, at;
        m0 = bus.o_spi_mosi;
        for (int k = 0; k < 8; k++) begin
            bus.i_leading_edge  = 1'($urandom_range(0, 1));
            bus.i_trailing_edge = 1'($urandom_range(0, 1));
            if (!bus.i_trailing_edge) bus.i_leading_edge = 1'b1;
            bus.i_spi_miso = 1'($urandom_range(0, 1));
            tick();
            got = {bus.o_spi_cs_n, bus.o_busy, bus.o_rx_valid, bus.o_tx_ready,
                   bus.o_clk_start, bus.o_spi_mosi, bus.o_rx_byte};
            exp = {5'b10010, m0, exp_last_rx};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL idle_strobe_%0d: got %b want %b", k, got, exp);
            end
        end
        bus.i_leading_edge  = 1'b0;
        bus.i_trailing_edge = 1'b0;
        for (int k = 0; k < 3; k++) begin
            w  = W'($urandom);
            at = $urandom_range(1, W - 2);
            xfer(w, 3, 0, at, ok, ms, mi, bm, csc);
            n_tests++;
            if (!ok || bm !== model_tx_bit(w, at) || bus.o_rx_byte !== w ||
                bus.o_rx_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL both_strobes: w=%h at=%0d mosi %b want %b rx %h valid %b",
                         w, at, bm, model_tx_bit(w, at), bus.o_rx_byte, bus.o_rx_valid);
            end
            repeat (2) tick();
        end
    endtask

    initial begin
        rst                 = 1'b1;
        bus.i_tx_valid      = 1'b0;
        bus.i_tx_byte       = '0;
        bus.i_leading_edge  = 1'b0;
        bus.i_trailing_edge = 1'b0;
        bus.i_spi_miso      = 1'b0;
        test_reset();
        test_loopback();
        test_fixed_miso();
        test_back_to_back();
        test_reset_abort();
        test_edges();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/spi_shift_engine.md
# spi_shift_engine

SPI mode-0 master data path. It accepts one DATAWIDTH-bit word per transfer over a valid/ready handshake, asserts chip select, and pulses a start strobe to the SPI clock-generation stage. It then consumes that stage's leading/trailing edge strobes to shift the word out on MOSI while shifting MISO into a receive register. It sits between the core-side bus interface and the SPI clock stage.

## Interface
- DATAWIDTH, 8, bits per transfer (≥2)
- i_clk  input  1  system clock
- i_reset  input  1  synchronous, active-high reset
- i_tx_valid  input  1  upstream word valid
- i_tx_byte  input  DATAWIDTH  word to transmit
- o_tx_ready  output  1  engine can accept a word
- o_clk_start  output  1  one-cycle pulse to the clock stage's start/valid input
- i_leading_edge  input  1  one-cycle strobe, SCLK rising (mode 0)
- i_trailing_edge  input  1  one-cycle strobe, SCLK falling (mode 0)
- o_spi_mosi  output  1  serial data out
- i_spi_miso  input  1  serial data in (pre-synchronised)
- o_spi_cs_n  output  1  chip select, active low
- o_rx_valid  output  1  one-cycle pulse, o_rx_byte valid
- o_rx_byte  output  DATAWIDTH  received word, held until next o_rx_valid
- o_busy  output  1  transfer in progress

## Operation
- All outputs are registered. Reset values: o_tx_ready=0, o_clk_start=0, o_spi_mosi=0, o_spi_cs_n=1, o_rx_valid=0, o_rx_byte=0, o_busy=0.
- FSM states: IDLE, SHIFT, DONE. Reset enters IDLE.
- IDLE:
  - o_tx_ready=1, o_spi_cs_n=1.
  - Edge strobes are ignored.
  - On i_tx_valid&&o_tx_ready: latch i_tx_byte into tx shift register, clear rx shift register, set bit counter=DATAWIDTH, and go to SHIFT.
- SHIFT (CPHA=0):
  - First bit is driven before the first leading edge.
  - On i_leading_edge: shift i_spi_miso into the rx register (MSB-first: shift left, insert at bit 0) and decrement the counter.
  - On i_trailing_edge with counter≠0: shift the tx register and drive the next bit on o_spi_mosi.
  - On i_trailing_edge with counter==0: go to DONE.
- DONE, one cycle:
  - o_rx_valid=1, o_rx_byte=rx register, o_spi_cs_n=1, o_busy=0.
  - Next state is IDLE.
- Leading and trailing strobes asserted in the same cycle: the leading edge is processed, the trailing edge is dropped, and o_spi_mosi is unchanged.
- i_tx_valid while not in IDLE: ignored, no word latched. Upstream must hold the word until the handshake completes.
- Counter width is $clog2(DATAWIDTH+1). The counter never wraps: a leading edge when counter==0 is ignored.
- Reset in any state: immediate return to IDLE with reset values. No o_rx_valid is emitted for the aborted transfer.

## Timing
- Accept at posedge N (valid&&ready).
- At N+1: o_spi_cs_n=0, o_busy=1, o_tx_ready=0, o_clk_start=1 (that cycle only), o_spi_mosi=first bit.
- MOSI updates 1 cycle after each trailing strobe. MISO is sampled on the posedge where the leading strobe is high.
- Final (DATAWIDTH-th) trailing strobe at posedge M: o_rx_valid=1 and o_spi_cs_n=1 at M+1; o_tx_ready=1 at M+2.
- Back-to-back: next accept no earlier than M+2. CS deasserts for at least 1 cycle between words.
- First o_tx_ready=1 is one cycle after i_reset deasserts.

## Configuration
- SPI_LSB_FIRST_EN
  - Defined: bit 0 transmitted first. Received bits shift in at the MSB (shift right), so o_rx_byte is in natural bit order.
  - Undefined (default): MSB first, as above.

## Test plan
- Loopback (MISO=MOSI), send 0xA5 with an ideal edge-strobe model (4-cycle half bit) -> MOSI sequence 1,0,1,0,0,1,0,1; o_rx_byte=0xA5 with one o_rx_valid pulse; cs_n low for exactly the transfer; one o_clk_start pulse.
- MISO tied 1, send 0x3C -> MOSI 0,0,1,1,1,1,0,0; o_rx_byte=0xFF. Then MISO tied 0, send 0xFF -> o_rx_byte=0x00.
- Hold i_tx_valid high with 0x11 then 0x22 continuously -> exactly two transfers; 0x22 accepted 2 cycles after the first o_rx_valid; cs_n high between them; no word lost or duplicated.
- Assert i_reset for one cycle after the 3rd leading strobe of 0xC3 -> next cycle cs_n=1, busy=0, no o_rx_valid; a following 0x5A loopback transfer returns 0x5A.
- Inject leading and trailing strobes in the same cycle mid-transfer -> MOSI unchanged that cycle, bit count decremented once. Strobes in IDLE -> no output change.
- With SPI_LSB_FIRST_EN defined, loopback 0x01 -> MOSI 1,0,0,0,0,0,0,0; o_rx_byte=0x01.
